// File: rtl/input_debouncer_pkg.sv
// Shared debounce definitions: state encodings, default parameters, state decode helpers.
package input_debouncer_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned CNT_W_DEF           = 16;
    localparam int unsigned STATE_W             = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_LOW    = 2'b00,
        WAIT_HIGH = 2'b01,
        ST_HIGH   = 2'b10,
        WAIT_LOW  = 2'b11
    } db_state_t;

    // Debounced level implied by a state: high once a rise has committed.
    function automatic logic state_level(input db_state_t s);
        return (s == ST_HIGH) || (s == WAIT_LOW);
    endfunction

    // True while a candidate level change is being qualified.
    function automatic logic state_waiting(input db_state_t s);
        return (s == WAIT_HIGH) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/input_debouncer_sync_2ff.sv
// Two-flop synchronizer for the raw asynchronous input; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // First stage captures the async level, second stage resolves metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Debouncer: synchronizes a raw level and accepts a new level only after it has
// been stable for DEBOUNCE_CYCLES synchronized cycles. a_db and busy are flops.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    output logic a_db,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             a_sync;
    db_state_t        state_q;
    db_state_t        state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             a_db_d;
    logic             busy_d;

    // Only the synchronizer's first stage ever sees the raw input.
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (a),
        .q     (a_sync)
    );

    // State register: state, qualification counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOW;
            count_q <= '0;
            a_db    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_db    <= a_db_d;
            busy    <= busy_d;
        end
    end

    // Next-state: enter WAIT on a level change, count while it holds, commit or abort.
    always_comb begin
        state_d = state_q;
        count_d = '0;
        case (state_q)
            ST_LOW: begin
                if (a_sync) begin
                    state_d = WAIT_HIGH;
                    count_d = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!a_sync) begin
                    state_d = ST_LOW;
                end else if (count_q >= CNT_MAX) begin
                    state_d = ST_HIGH;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!a_sync) begin
                    state_d = WAIT_LOW;
                    count_d = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (a_sync) begin
                    state_d = ST_HIGH;
                end else if (count_q >= CNT_MAX) begin
                    state_d = ST_LOW;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
            end
        endcase
    end

    // Output decode from the next state so the flopped outputs track the state register.
    always_comb begin
        a_db_d = 1'b0;
        busy_d = 1'b0;
        a_db_d = state_level(state_d);
        busy_d = state_waiting(state_d);
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed, table-driven bench for input_debouncer with a downstream falling-edge model.
module tb_input_debouncer;
    import input_debouncer_pkg::*;

    typedef struct packed {
        logic a;
        logic exp_db;
        logic exp_busy;
    } vec_t;

    logic clk;
    logic reset;
    logic a;
    logic a_db;
    logic busy;

    int checks;
    int failures;
    int pulses;

    vec_t vecs[$];

    logic db_q;
    logic exp_out;

    input_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_DEF),
        .CNT_W           (CNT_W_DEF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .a_db  (a_db),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream negative edge detector fed by a_db.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) db_q <= 1'b0;
        else        db_q <= a_db;
    end
    assign exp_out = db_q & ~a_db;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic av, input logic db, input logic b);
        vec_t v;
        v.a        = av;
        v.exp_db   = db;
        v.exp_busy = b;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic av, input logic db, input logic b);
        for (int i = 0; i < n; i++) add(av, db, b);
    endtask

    // Drive a, take one rising edge, sample 1 ns later and count detector pulses.
    task automatic step(input logic av);
        a = av;
        @(posedge clk);
        #1;
        if (exp_out) pulses++;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pulses   = 0;
        reset    = 1'b0;
        a        = 1'b0;

        // Expected outputs after each edge; FSM reacts to a driven two edges earlier.
        add_n(3, 1'b0, 1'b0, 1'b0);
        // Clean rise: sampled at E1, busy E3..E5, a_db at E6
        add_n(2, 1'b1, 1'b0, 1'b0);
        add_n(3, 1'b1, 1'b0, 1'b1);
        add_n(3, 1'b1, 1'b1, 1'b0);
        // Clean fall
        add_n(2, 1'b0, 1'b1, 1'b0);
        add_n(3, 1'b0, 1'b1, 1'b1);
        add_n(3, 1'b0, 1'b0, 1'b0);
        // Glitch of 3 sampled cycles: busy 3 cycles, no change
        add_n(2, 1'b1, 1'b0, 1'b0);
        add  (   1'b1, 1'b0, 1'b1);
        add_n(2, 1'b0, 1'b0, 1'b1);
        add_n(4, 1'b0, 1'b0, 1'b0);
        // Minimum accept of 4 sampled cycles, then fall
        add_n(2, 1'b1, 1'b0, 1'b0);
        add_n(2, 1'b1, 1'b0, 1'b1);
        add  (   1'b0, 1'b0, 1'b1);
        add  (   1'b0, 1'b1, 1'b0);
        add_n(3, 1'b0, 1'b1, 1'b1);
        add_n(3, 1'b0, 1'b0, 1'b0);
        // Bounce 1,0,1,0,1 then hold 1
        add  (   1'b1, 1'b0, 1'b0);
        add  (   1'b0, 1'b0, 1'b0);
        add  (   1'b1, 1'b0, 1'b1);
        add  (   1'b0, 1'b0, 1'b0);
        add  (   1'b1, 1'b0, 1'b1);
        add  (   1'b1, 1'b0, 1'b0);
        add_n(3, 1'b1, 1'b0, 1'b1);
        add_n(3, 1'b1, 1'b1, 1'b0);

        // Reset state
        #1;
        check("reset_async_db", a_db, 1'b0);
        check("reset_async_busy", busy, 1'b0);
        a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold_db", a_db, 1'b0);
        check("reset_hold_busy", busy, 1'b0);
        a = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_no_change_busy", busy, 1'b0);

        // Table vectors
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].a);
            check($sformatf("vec%0d_db", i), a_db, vecs[i].exp_db);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
        end

        // Return low, then reset during WAIT_HIGH at count=2
        repeat (8) step(1'b0);
        check("pre_rst_db", a_db, 1'b0);
        repeat (4) step(1'b1);
        check("mid_wait_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_db", a_db, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        check("in_rst_edge_busy", busy, 1'b0);
        check("in_rst_edge_db", a_db, 1'b0);
        reset = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst%0d_db", r), a_db, (r == 6) ? 1'b1 : 1'b0);
            check($sformatf("post_rst%0d_busy", r), busy, (r >= 3 && r <= 5) ? 1'b1 : 1'b0);
        end

        // Chain with downstream falling-edge detector
        repeat (2) step(1'b1);
        pulses = 0;
        repeat (3) step(1'b0);
        repeat (6) step(1'b1);
        check("chain_glitch_db", a_db, 1'b1);
        check_int("chain_glitch_pulses", pulses, 0);
        repeat (8) step(1'b0);
        check("chain_fall_db", a_db, 1'b0);
        check_int("chain_fall_pulses", pulses, 1);
        repeat (3) step(1'b1);
        repeat (6) step(1'b0);
        check_int("chain_low_glitch_pulses", pulses, 1);
        check("chain_low_glitch_db", a_db, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive synchronized cycles required to accept a new level (legal range 2..65535).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the counter width; it SHALL hold DEBOUNCE_CYCLES-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port a, input, 1 bit: raw asynchronous level (button or switch).
REQ-006 The block SHALL have port a_db, output, 1 bit: debounced level, fed directly to the downstream negative edge detector input.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-008 Input a SHALL pass through a two-flop synchronizer; its second-stage output is a_sync; no logic SHALL read a before the first stage.
REQ-009 The FSM SHALL have four states: ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW; a_db = 1 only in ST_HIGH and WAIT_LOW.
REQ-010 In ST_LOW with a_sync=1, the FSM SHALL go to WAIT_HIGH with count=1; in ST_HIGH with a_sync=0, it SHALL go to WAIT_LOW with count=1.
REQ-011 In WAIT_x with a_sync still at the candidate level and count<DEBOUNCE_CYCLES-1, count SHALL increment by 1.
REQ-012 In WAIT_x with a_sync at the candidate level and count==DEBOUNCE_CYCLES-1, the FSM SHALL commit: go to ST_HIGH/ST_LOW, toggle a_db on that edge, and clear count to 0.
REQ-013 In WAIT_x with a_sync back at the current a_db level, the FSM SHALL abort to the originating ST_x, clear count, and leave a_db unchanged.
REQ-014 A level change on a held stable SHALL appear on a_db exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new value into the synchronizer.
REQ-015 A pulse on a_sync shorter than DEBOUNCE_CYCLES cycles SHALL never change a_db.
REQ-016 busy SHALL be 1 exactly in WAIT_HIGH and WAIT_LOW, registered, with no combinational path from a.
REQ-017 a_db SHALL be driven directly from a flop so the downstream edge detector sees a glitch-free level.
REQ-018 count SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL NOT wrap; it is 0 in every ST_x state.
REQ-019 Any unreachable state encoding SHALL recover to ST_LOW on the next edge with a_db=0 and count=0.

Reset
REQ-020 While reset=0, both synchronizer flops, count, and a_db SHALL be 0, the state SHALL be ST_LOW, and busy SHALL be 0, asynchronously.
REQ-021 Reset asserted mid-WAIT SHALL discard the candidate; after release, qualification SHALL restart from ST_LOW.
REQ-022 Reset release SHALL take effect on the first rising clk edge with reset=1; no output SHALL change before that edge.

Structure
REQ-023 State encodings (2-bit) and the default DEBOUNCE_CYCLES SHALL live in the shared debounce definitions package/include, reused by the testbench.
REQ-024 The two-flop synchronizer SHALL be a separate sub-module sync_2ff (clk, reset, d, q; async active-low clear to 0).
REQ-025 The FSM and counter SHALL be in input_debouncer, in one sequential process plus one next-state process, and implementation SHALL be 120-400 lines total.

Verification (DEBOUNCE_CYCLES=4, clk period 10 ns)
REQ-026 Clean step: a 0->1 sampled at edge E1, then held -> a_db rises at edge E6; busy is high from E3 to E5 and low at E6.
REQ-027 Glitch rejection: a high for exactly 3 sampled cycles, then 0 -> a_db stays 0; busy pulses high for 3 cycles, then returns to 0.
REQ-028 Minimum accept: a high for exactly 4 sampled cycles -> a_db rises to 1; a subsequent 0 held -> a_db falls 6 edges after sampling.
REQ-029 Bounce: a toggles 1,0,1,0,1 every cycle, then holds 1 -> a_db rises exactly 6 edges after the final 0->1 sample, with no earlier transition.
REQ-030 Reset mid-WAIT: reset=0 for 1 cycle during WAIT_HIGH at count=2 -> a_db=0, busy=0 immediately; with a held 1, a_db rises 6 edges after release.
REQ-031 Chain with the downstream negative edge detector: a 1->0 held -> exactly one exp_out pulse following the a_db fall, and none for any rejected glitch.
